// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer slice: FSM encoding,
// command kinds and datapath widths.
package alu_seq_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 2;
  localparam int NUM_REGS  = 2 ** REG_IDX_W;

  localparam logic KIND_ALU  = 1'b0;
  localparam logic KIND_LOAD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } seq_state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Four-entry register file: two asynchronous read ports, one synchronous
// write port, synchronously cleared by rst.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr_a,
  output logic [DATA_W-1:0]    rdata_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  output logic [DATA_W-1:0]    rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences commands onto an external combinational ALU: reads operands,
// drives the ALU for one cycle, captures the result and hands it back.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_kind,
  input  logic                 cmd_mode,
  input  logic [3:0]           cmd_select,
  input  logic [REG_IDX_W-1:0] cmd_rd,
  input  logic [REG_IDX_W-1:0] cmd_ra,
  input  logic [REG_IDX_W-1:0] cmd_rb,
  input  logic                 cmd_use_carry,
  input  logic [DATA_W-1:0]    cmd_imm,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_carry,
  output logic                 alu_mode,
  output logic [3:0]           alu_select,
  output logic                 alu_carry_in,
  output logic [DATA_W-1:0]    alu_in_a,
  output logic [DATA_W-1:0]    alu_in_b,
  input  logic [DATA_W-1:0]    alu_out,
  input  logic                 alu_carry_out
);

  seq_state_t state, state_next;

  logic                 accept;
  logic                 capture;
  logic                 rsp_fire;
  logic                 is_load;
  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;
  logic [DATA_W-1:0]    rdata_a;
  logic [DATA_W-1:0]    rdata_b;

  // Fields still needed after the ALU drive registers have absorbed the rest
  logic [REG_IDX_W-1:0] rd_q;
  logic                 mode_q;
  logic                 carry_flag;
  logic [15:0]          op_count;

  assign is_load = (cmd_kind == KIND_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = is_load ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE:   state_next = ST_CAPTURE;
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_fire   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rsp_valid = (state == ST_RESP);

  // Loads write at acceptance; ALU results write when captured
  assign rf_we    = (accept && is_load) || capture;
  assign rf_waddr = capture ? rd_q : cmd_rd;
  assign rf_wdata = capture ? alu_out : cmd_imm;

  alu_seq_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (cmd_ra),
    .rdata_a (rdata_a),
    .raddr_b (cmd_rb),
    .rdata_b (rdata_b)
  );

  // Operands are sampled at acceptance, so a destination that aliases a
  // source still sees the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q         <= '0;
      mode_q       <= 1'b0;
      carry_flag   <= 1'b0;
      op_count     <= '0;
      rsp_data     <= '0;
      rsp_carry    <= 1'b0;
      alu_mode     <= 1'b0;
      alu_select   <= '0;
      alu_carry_in <= 1'b0;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
    end else begin
      if (accept) begin
        rd_q   <= cmd_rd;
        mode_q <= cmd_mode;
        if (is_load) begin
          rsp_data  <= cmd_imm;
          rsp_carry <= carry_flag;
        end else begin
          alu_mode     <= cmd_mode;
          alu_select   <= cmd_select;
          alu_carry_in <= cmd_use_carry & carry_flag;
          alu_in_a     <= rdata_a;
          alu_in_b     <= rdata_b;
        end
      end
      if (capture) begin
        rsp_data <= alu_out;
        if (mode_q) begin
          rsp_carry <= carry_flag;
        end else begin
          rsp_carry  <= alu_carry_out;
          carry_flag <= alu_carry_out;
        end
      end
      if (rsp_fire) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural ALU drives alu_out, a
// register/carry model predicts each response, a monitor branch checks them.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_kind = 1'b0;
  logic        cmd_mode = 1'b0;
  logic [3:0]  cmd_select = '0;
  logic [1:0]  cmd_rd = '0;
  logic [1:0]  cmd_ra = '0;
  logic [1:0]  cmd_rb = '0;
  logic        cmd_use_carry = 1'b0;
  logic [15:0] cmd_imm = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_carry;
  logic        alu_mode;
  logic [3:0]  alu_select;
  logic        alu_carry_in;
  logic [15:0] alu_in_a;
  logic [15:0] alu_in_b;
  logic [15:0] alu_out;
  logic        alu_carry_out;

  int checks = 0;
  int failures = 0;
  int handshakes = 0;
  int count_base = 0;

  logic [15:0] m_regs [4];
  logic        m_carry;
  logic [16:0] exp_q [$];

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_kind      (cmd_kind),
    .cmd_mode      (cmd_mode),
    .cmd_select    (cmd_select),
    .cmd_rd        (cmd_rd),
    .cmd_ra        (cmd_ra),
    .cmd_rb        (cmd_rb),
    .cmd_use_carry (cmd_use_carry),
    .cmd_imm       (cmd_imm),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_carry     (rsp_carry),
    .alu_mode      (alu_mode),
    .alu_select    (alu_select),
    .alu_carry_in  (alu_carry_in),
    .alu_in_a      (alu_in_a),
    .alu_in_b      (alu_in_b),
    .alu_out       (alu_out),
    .alu_carry_out (alu_carry_out)
  );

  // Behavioural ALU: {carry, result}. Logic ops return an unrelated carry bit
  // so a sequencer that forwards it instead of the stored flag is exposed.
  function automatic logic [16:0] alu_model(input logic mode, input logic [3:0] sel,
                                            input logic cin, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [15:0] v;
    if (!mode) begin
      case (sel)
        4'b0110: return {1'b0, a} + {1'b0, ~b} + {16'd0, cin};
        4'b0000: return {1'b0, a} + {16'd0, cin};
        default: return {1'b0, a} + {1'b0, b} + {16'd0, cin};
      endcase
    end
    case (sel)
      4'b0000: v = ~a;
      4'b0110: v = a ^ b;
      4'b1001: v = ~(a ^ b);
      4'b1011: v = a & b;
      4'b1110: v = a | b;
      4'b0011: v = 16'h0000;
      4'b1100: v = 16'hFFFF;
      default: v = a;
    endcase
    return {a[0] ^ b[0], v};
  endfunction

  always_comb {alu_carry_out, alu_out} = alu_model(alu_mode, alu_select, alu_carry_in,
                                                   alu_in_a, alu_in_b);

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic scramble_cmd();
    cmd_kind      = 1'($urandom);
    cmd_mode      = 1'($urandom);
    cmd_select    = 4'($urandom);
    cmd_rd        = 2'($urandom);
    cmd_ra        = 2'($urandom);
    cmd_rb        = 2'($urandom);
    cmd_use_carry = 1'($urandom);
    cmd_imm       = 16'($urandom);
  endtask

  task automatic doReset(input int n);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
    m_carry    = 1'b0;
    count_base = handshakes;
  endtask

  task automatic checkResetState();
    @(negedge clk);
    checkOutput("reset_cmd_ready", 16'(cmd_ready), 16'd1);
    checkOutput("reset_rsp_valid", 16'(rsp_valid), 16'd0);
    checkOutput("reset_rsp_data", rsp_data, 16'h0000);
    checkOutput("reset_rsp_carry", 16'(rsp_carry), 16'd0);
    checkOutput("reset_alu_ctrl", {10'd0, alu_mode, alu_select, alu_carry_in}, 16'd0);
    checkOutput("reset_alu_in_a", alu_in_a, 16'h0000);
    checkOutput("reset_alu_in_b", alu_in_b, 16'h0000);
    checkOutput("reset_op_count", dut.op_count, 16'h0000);
  endtask

  task automatic applyStimulus(input logic kind, input logic mode, input logic [3:0] sel,
                               input logic [1:0] rd, input logic [1:0] ra,
                               input logic [1:0] rb, input logic use_carry,
                               input logic [15:0] imm, input int stall, input bit abort);
    int          wait_cnt;
    logic [15:0] a, b, exp_data, held_data;
    logic        cin, exp_carry, held_carry;
    logic [16:0] res;
    @(posedge clk);
    #1;
    wait_cnt = 0;
    while (!cmd_ready && wait_cnt < 20) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_ready_wait", 16'(cmd_ready), 16'd1);
      doReset(2);
      return;
    end
    cmd_kind = kind; cmd_mode = mode; cmd_select = sel;
    cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    cmd_use_carry = use_carry; cmd_imm = imm;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    scramble_cmd();
    if (abort) begin
      doReset(1);
      checkResetState();
      return;
    end
    a = m_regs[ra];
    b = m_regs[rb];
    cin = use_carry & m_carry;
    if (kind == KIND_LOAD) begin
      exp_data  = imm;
      exp_carry = m_carry;
      m_regs[rd] = imm;
    end else begin
      res       = alu_model(mode, sel, cin, a, b);
      exp_data  = res[15:0];
      exp_carry = mode ? m_carry : res[16];
      if (!mode) m_carry = res[16];
      m_regs[rd] = res[15:0];
    end
    exp_q.push_back({exp_carry, exp_data});
    if (kind == KIND_ALU) begin
      @(negedge clk);
      checkOutput("issue_alu_in_a", alu_in_a, a);
      checkOutput("issue_alu_in_b", alu_in_b, b);
      checkOutput("issue_alu_ctrl", {10'd0, alu_mode, alu_select, alu_carry_in},
                  {10'd0, mode, sel, cin});
      checkOutput("issue_rsp_valid", 16'(rsp_valid), 16'd0);
      @(negedge clk);
      checkOutput("hold_alu_in_a", alu_in_a, a);
      checkOutput("capture_rsp_valid", 16'(rsp_valid), 16'd0);
      @(negedge clk);
      checkOutput("alu_latency", 16'(rsp_valid), 16'd1);
    end else begin
      @(negedge clk);
      checkOutput("load_latency", 16'(rsp_valid), 16'd1);
    end
    wait_cnt = 0;
    while (!rsp_valid && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!rsp_valid) begin
      doReset(2);
      return;
    end
    held_data  = rsp_data;
    held_carry = rsp_carry;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      scramble_cmd();
      cmd_valid = 1'($urandom);
      @(negedge clk);
      checkOutput("stall_rsp_data", rsp_data, held_data);
      checkOutput("stall_rsp_carry", 16'(rsp_carry), 16'(held_carry));
      checkOutput("stall_cmd_ready", 16'(cmd_ready), 16'd0);
      checkOutput("stall_rsp_valid", 16'(rsp_valid), 16'd1);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic k;
    for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
    m_carry = 1'b0;
    fork
      begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
      end
      forever begin
        @(negedge clk);
        if (!rst && rsp_valid && rsp_ready) begin
          handshakes++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_rsp", 16'(rsp_valid), 16'd0);
          end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            checkOutput("rsp_data", rsp_data, e[15:0]);
            checkOutput("rsp_carry", 16'(rsp_carry), 16'(e[16]));
          end
        end
      end
    join_none

    doReset(3);
    checkResetState();

    $display("[TB] directed: add 5 + 3");
    applyStimulus(KIND_LOAD, 0, 4'b0000, 2'd0, 2'd0, 2'd0, 0, 16'h0005, 0, 0);
    applyStimulus(KIND_LOAD, 0, 4'b0000, 2'd1, 2'd0, 2'd0, 0, 16'h0003, 1, 0);
    applyStimulus(KIND_ALU, 0, 4'b1001, 2'd2, 2'd0, 2'd1, 0, 16'h0000, 0, 0);

    $display("[TB] directed: carry chain with logic op in between");
    applyStimulus(KIND_LOAD, 0, 4'b0000, 2'd0, 2'd0, 2'd0, 0, 16'hFFFF, 0, 0);
    applyStimulus(KIND_LOAD, 0, 4'b0000, 2'd1, 2'd0, 2'd0, 0, 16'h0001, 0, 0);
    applyStimulus(KIND_ALU, 0, 4'b1001, 2'd2, 2'd0, 2'd1, 0, 16'h0000, 0, 0);
    applyStimulus(KIND_LOAD, 0, 4'b0000, 2'd0, 2'd0, 2'd0, 0, 16'h00FF, 0, 0);
    applyStimulus(KIND_LOAD, 0, 4'b0000, 2'd1, 2'd0, 2'd0, 0, 16'h0F0F, 0, 0);
    applyStimulus(KIND_ALU, 1, 4'b0110, 2'd2, 2'd0, 2'd1, 0, 16'h0000, 0, 0);
    applyStimulus(KIND_ALU, 0, 4'b1001, 2'd3, 2'd3, 2'd3, 1, 16'h0000, 5, 0);

    $display("[TB] directed: aliasing and long stall");
    applyStimulus(KIND_ALU, 0, 4'b1001, 2'd0, 2'd0, 2'd0, 0, 16'h0000, 5, 0);

    $display("[TB] directed: reset during issue");
    applyStimulus(KIND_LOAD, 0, 4'b0000, 2'd0, 2'd0, 2'd0, 0, 16'h1234, 0, 0);
    applyStimulus(KIND_ALU, 1, 4'b1110, 2'd2, 2'd0, 2'd0, 0, 16'h0000, 0, 1);
    applyStimulus(KIND_ALU, 1, 4'b1110, 2'd1, 2'd2, 2'd2, 0, 16'h0000, 0, 0);
    applyStimulus(KIND_ALU, 0, 4'b1001, 2'd1, 2'd2, 2'd2, 1, 16'h0000, 0, 0);

    $display("[TB] random commands");
    for (int i = 0; i < 60; i++) begin
      k = ($urandom_range(0, 9) < 3);
      applyStimulus(k, 1'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
                    2'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 3),
                    (i % 17 == 9) && (k == KIND_ALU));
    end

    @(negedge clk);
    checkOutput("op_count", dut.op_count, 16'(handshakes - count_base));
    checkOutput("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset sampled on rising edge of clk.
REQ-003 SHALL have port cmd_valid, input, 1, command offered.
REQ-004 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-005 SHALL have port cmd_kind, input, 1, 0 = ALU op, 1 = load immediate.
REQ-006 SHALL have ports cmd_mode (input, 1; 1 = logic, 0 = arithmetic) and cmd_select (input, 4; ALU function code).
REQ-007 SHALL have ports cmd_rd, cmd_ra, cmd_rb, each input, 2, destination and source register indices.
REQ-008 SHALL have port cmd_use_carry, input, 1, 1 = feed stored carry flag to ALU carry input.
REQ-009 SHALL have port cmd_imm, input, 16, immediate for load.
REQ-010 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, 16), rsp_carry (output, 1): result channel.
REQ-011 SHALL have ALU-drive ports alu_mode (output, 1), alu_select (output, 4), alu_carry_in (output, 1), alu_in_a (output, 16), alu_in_b (output, 16).
REQ-012 SHALL have ALU-return ports alu_out (input, 16) and alu_carry_out (input, 1), combinational function of the drive ports.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP; cmd_ready = 1 only in IDLE.
REQ-014 SHALL latch all cmd_* fields on acceptance; later cmd_* changes have no effect.
REQ-015 On accepted ALU op (edge T): state ISSUE for cycle T+1; alu_* outputs registered, stable for whole cycle: alu_in_a = R[ra], alu_in_b = R[rb], alu_mode/alu_select from command, alu_carry_in = use_carry ? carry_flag : 0.
REQ-016 At edge T+2 SHALL write alu_out into R[rd], load rsp_data = alu_out, rsp_carry = alu_carry_out, enter RESP; rsp_valid high from cycle T+2.
REQ-017 carry_flag SHALL update to alu_carry_out only for mode = 0 ops; mode = 1 ops leave carry_flag unchanged and rsp_carry = current carry_flag.
REQ-018 On accepted load (edge T): write cmd_imm into R[rd], rsp_data = cmd_imm, rsp_carry = carry_flag, go directly to RESP; rsp_valid high from T+1; carry_flag unchanged.
REQ-019 In RESP, rsp_valid, rsp_data, rsp_carry SHALL hold until rsp_valid && rsp_ready at an edge, then return to IDLE; next command acceptable the cycle after.
REQ-020 rd equal to ra or rb SHALL be legal; sources read pre-write values.
REQ-021 alu_* outputs SHALL hold last driven values outside ISSUE (no toggling).
REQ-022 SHALL count completed responses in internal 16-bit op_count, wrapping 0xFFFF -> 0x0000.

Reset
REQ-023 rst SHALL, from any state including ISSUE/CAPTURE/RESP, force IDLE at next edge, abandoning the in-flight command without writeback.
REQ-024 Reset values: R0..R3 = 0x0000, carry_flag = 0, op_count = 0, rsp_valid = 0, rsp_data = 0x0000, rsp_carry = 0, all alu_* outputs = 0, cmd_ready = 1 in first cycle after reset release.

Structure
REQ-025 Package alu_seq_pkg SHALL hold the FSM state encoding, KIND_ALU/KIND_LOAD constants, and data width (16) and register-index width (2).
REQ-026 Register file SHALL be sub-module alu_seq_regfile: 4 x 16, two async read ports, one sync write port, synchronous reset to zero.

Verification
REQ-027 Load R0 = 0x0005, R1 = 0x0003; ALU op mode 0, select 1001, ra 0, rb 1, rd 2, use_carry 0 -> rsp_data 0x0008, rsp_carry 0, rsp_valid 2 cycles after acceptance.
REQ-028 Load R0 = 0xFFFF, R1 = 0x0001; add (mode 0, select 1001) -> 0x0000 carry 1; then add R3+R3 with use_carry 1 -> 0x0001, alu_carry_in observed 1 in ISSUE.
REQ-029 Load R0 = 0x00FF, R1 = 0x0F0F; mode 1, select 0110 -> rsp_data 0x0FF0, carry_flag unchanged from prior value.
REQ-030 rsp_ready held low 5 cycles after rsp_valid -> rsp_data/rsp_carry stable, cmd_ready 0 throughout, cmd_valid pulses ignored.
REQ-031 rst asserted during ISSUE of op targeting R2 = 0x1234 -> next cycle IDLE, R2 reads 0x0000, rsp_valid 0, carry_flag 0.
